// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle MIPS32 control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB, issues per-phase datapath enables,
// handles the memory ready handshake, stalls for the multiply/divide unit
// and counts retired instructions.
module mc_control_unit #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic [4:0]           rt,
  input  logic                 branch_cond,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 reg_we,
  output logic                 link,
  output logic                 hilo_we,
  output logic                 mdu_start,
  output logic                 illegal,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] retired_cnt,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_RST      = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_MEM      = 3'd4,
    S_WB       = 3'd5,
    S_MDU_WAIT = 3'd6,
    S_TRAP     = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    K_ALU,      // R-ALU, shifts, I-ALU, LUI, MFHI/MFLO: finish in WB
    K_LOAD,
    K_STORE,
    K_BRANCH,
    K_J,
    K_JAL,
    K_JR,
    K_JALR,
    K_MTHL,
    K_MDU,
    K_ILLEGAL
  } kind_e;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JMP  = 2'd2;
  localparam logic [1:0] PC_REG  = 2'd3;
  localparam logic [7:0] MDU_LOAD = 8'(MDU_LATENCY - 1);

  state_e               state_q, state_d;
  kind_e                kind_q, kind_d, kind_dec;
  logic [7:0]           mdu_cnt_q, mdu_cnt_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Classify the instruction currently held in IR
  always_comb begin
    kind_dec = K_ILLEGAL;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B, 6'h10, 6'h12:  kind_dec = K_ALU;
          6'h08:                       kind_dec = K_JR;
          6'h09:                       kind_dec = K_JALR;
          6'h11, 6'h13:                kind_dec = K_MTHL;
          6'h18, 6'h19, 6'h1A, 6'h1B:  kind_dec = K_MDU;
          default:                     kind_dec = K_ILLEGAL;
        endcase
      end
      6'h01: begin
        if (rt == 5'h00 || rt == 5'h01) kind_dec = K_BRANCH;
      end
      6'h02:                                     kind_dec = K_J;
      6'h03:                                     kind_dec = K_JAL;
      6'h04, 6'h05, 6'h06, 6'h07:                kind_dec = K_BRANCH;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:                kind_dec = K_ALU;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25:         kind_dec = K_LOAD;
      6'h28, 6'h29, 6'h2B:                       kind_dec = K_STORE;
      default:                                   kind_dec = K_ILLEGAL;
    endcase
  end

  // Next state, per-phase enables and retire pulse
  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    kind_d    = kind_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SEQ;
    reg_we    = 1'b0;
    link      = 1'b0;
    hilo_we   = 1'b0;
    mdu_start = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        kind_d  = kind_dec;
        state_d = (kind_dec == K_ILLEGAL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (kind_q)
          K_BRANCH: begin
            pc_we = branch_cond; pc_src = PC_BR; retire = 1'b1; state_d = S_FETCH;
          end
          K_J: begin
            pc_we = 1'b1; pc_src = PC_JMP; retire = 1'b1; state_d = S_FETCH;
          end
          K_JAL: begin
            pc_we = 1'b1; pc_src = PC_JMP; reg_we = 1'b1; link = 1'b1;
            retire = 1'b1; state_d = S_FETCH;
          end
          K_JR: begin
            pc_we = 1'b1; pc_src = PC_REG; retire = 1'b1; state_d = S_FETCH;
          end
          K_JALR: begin
            pc_we = 1'b1; pc_src = PC_REG; reg_we = 1'b1; link = 1'b1;
            retire = 1'b1; state_d = S_FETCH;
          end
          K_MTHL: begin
            hilo_we = 1'b1; retire = 1'b1; state_d = S_FETCH;
          end
          K_MDU: begin
            mdu_start = 1'b1; mdu_cnt_d = MDU_LOAD; state_d = S_MDU_WAIT;
          end
          K_LOAD, K_STORE: state_d = S_MEM;
          K_ALU:           state_d = S_WB;
          default:         state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (kind_q == K_STORE);
        if (mem_ready) begin
          if (kind_q == K_STORE) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MDU_WAIT: begin
        // Counter was loaded with latency-1, so the zero cycle is the last busy cycle
        if (mdu_cnt_q == 8'd0) begin
          hilo_we = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          mdu_cnt_d = mdu_cnt_q - 8'd1;
        end
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_RST;
    endcase
  end

  // Sticky illegal flag and retired-instruction counter next values
  always_comb begin
    illegal_d = illegal_q | ((state_q == S_DECODE) && (kind_dec == K_ILLEGAL));
    cnt_d     = retire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  // State, instruction class, MDU counter, flag and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      kind_q    <= K_ALU;
      mdu_cnt_q <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      mdu_cnt_q <= mdu_cnt_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign illegal     = illegal_q;
  assign retired_cnt = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed testbench for mc_control_unit. A second instance with a one-cycle
// MDU latency and a 2-bit retire counter shares the same stimulus.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  rt = '0;
  logic        branch_cond = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_we, ir_we, pc_we, reg_we, link, hilo_we, mdu_start, illegal, retire;
  logic [1:0]  pc_src;
  logic [31:0] retired_cnt;
  logic [2:0]  state;

  logic        m1_mem_req, m1_mem_we, m1_ir_we, m1_pc_we, m1_reg_we, m1_link;
  logic        m1_hilo_we, m1_mdu_start, m1_illegal, m1_retire;
  logic [1:0]  m1_pc_src;
  logic [1:0]  m1_retired_cnt;
  logic [2:0]  m1_state;

  int checks = 0;
  int errors = 0;

  // {state, mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, link, hilo_we, mdu_start, illegal, retire}
  logic [14:0] ctl, m1_ctl;
  assign ctl    = {state, mem_req, mem_we, ir_we, pc_we, pc_src,
                   reg_we, link, hilo_we, mdu_start, illegal, retire};
  assign m1_ctl = {m1_state, m1_mem_req, m1_mem_we, m1_ir_we, m1_pc_we, m1_pc_src,
                   m1_reg_we, m1_link, m1_hilo_we, m1_mdu_start, m1_illegal, m1_retire};

  localparam logic [14:0] C_FETCH_GO = 15'b001_1011_00_0000_00;
  localparam logic [14:0] C_FETCH_WT = 15'b001_1000_00_0000_00;
  localparam logic [14:0] C_DECODE   = 15'b010_0000_00_0000_00;
  localparam logic [14:0] C_EXEC_NOP = 15'b011_0000_00_0000_00;
  localparam logic [14:0] C_WB       = 15'b101_0000_00_1000_01;

  mc_control_unit #(.MDU_LATENCY(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rt(rt),
    .branch_cond(branch_cond), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .link(link), .hilo_we(hilo_we),
    .mdu_start(mdu_start), .illegal(illegal), .retire(retire),
    .retired_cnt(retired_cnt), .state(state)
  );

  mc_control_unit #(.MDU_LATENCY(1), .CNT_WIDTH(2)) dut_m1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rt(rt),
    .branch_cond(branch_cond), .mem_ready(mem_ready),
    .mem_req(m1_mem_req), .mem_we(m1_mem_we), .ir_we(m1_ir_we), .pc_we(m1_pc_we),
    .pc_src(m1_pc_src), .reg_we(m1_reg_we), .link(m1_link), .hilo_we(m1_hilo_we),
    .mdu_start(m1_mdu_start), .illegal(m1_illegal), .retire(m1_retire),
    .retired_cnt(m1_retired_cnt), .state(m1_state)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; branch_cond = 1'b0;
    opcode = '0; funct = '0; rt = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Advance one clock, then apply this cycle's mem_ready and let outputs settle
  task automatic cyc(input logic rdy);
    @(posedge clk);
    #1 mem_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== 15'd0) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 15'd0); end
    checks++;
    if (retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", retired_cnt); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (ctl !== 15'd0) begin errors++; $display("FAIL rst_state_ctl: got %b expected %b", ctl, 15'd0); end
    cyc(1'b0);
    checks++;
    if (ctl !== C_FETCH_WT) begin errors++; $display("FAIL reset_to_fetch: got %b expected %b", ctl, C_FETCH_WT); end
  endtask

  task automatic test_add();
    logic [14:0] exp [5] = '{C_FETCH_GO, C_DECODE, C_EXEC_NOP, C_WB, C_FETCH_GO};
    do_reset();
    opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      checks++;
      if (ctl !== exp[i]) begin errors++; $display("FAIL add_ctl c%0d: got %b expected %b", i + 1, ctl, exp[i]); end
    end
    checks++;
    if (retired_cnt !== 32'd1) begin errors++; $display("FAIL add_cnt: got %0d expected 1", retired_cnt); end
  endtask

  task automatic test_lw_stall();
    logic        rdy [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [14:0] exp [11] = '{C_FETCH_WT, C_FETCH_WT, C_FETCH_GO, C_DECODE, C_EXEC_NOP,
                              15'b100_1000_00_0000_00, 15'b100_1000_00_0000_00,
                              15'b100_1000_00_0000_00, 15'b100_1000_00_0000_00,
                              C_WB, C_FETCH_GO};
    do_reset();
    opcode = 6'h23;
    for (int i = 0; i < 11; i++) begin
      cyc(rdy[i]);
      checks++;
      if (ctl !== exp[i]) begin errors++; $display("FAIL lw_ctl c%0d: got %b expected %b", i + 1, ctl, exp[i]); end
    end
    checks++;
    if (retired_cnt !== 32'd1) begin errors++; $display("FAIL lw_cnt: got %0d expected 1", retired_cnt); end
  endtask

  task automatic test_sw();
    logic [14:0] exp [5] = '{C_FETCH_GO, C_DECODE, C_EXEC_NOP,
                             15'b100_1100_00_0000_01, C_FETCH_GO};
    do_reset();
    opcode = 6'h2B;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1);
      checks++;
      if (ctl !== exp[i]) begin errors++; $display("FAIL sw_ctl c%0d: got %b expected %b", i + 1, ctl, exp[i]); end
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0]  ops  [5] = '{6'h04, 6'h04, 6'h03, 6'h00, 6'h00};
    logic [5:0]  fns  [5] = '{6'h00, 6'h00, 6'h00, 6'h11, 6'h08};
    logic        bcs  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [14:0] exec [5] = '{15'b011_0001_01_0000_01,   // BEQ taken
                              15'b011_0000_01_0000_01,   // BEQ not taken
                              15'b011_0001_10_1100_01,   // JAL
                              15'b011_0000_00_0010_01,   // MTHI
                              15'b011_0001_11_0000_01};  // JR
    logic [14:0] exp;
    for (int s = 0; s < 5; s++) begin
      do_reset();
      opcode = ops[s]; funct = fns[s]; branch_cond = bcs[s];
      for (int i = 0; i < 4; i++) begin
        cyc(1'b1);
        exp = (i == 0 || i == 3) ? C_FETCH_GO : (i == 1) ? C_DECODE : exec[s];
        checks++;
        if (ctl !== exp) begin
          errors++; $display("FAIL bj_ctl case%0d c%0d: got %b expected %b", s, i + 1, ctl, exp);
        end
      end
    end
  endtask

  task automatic test_mdu();
    logic [14:0] ex_mdu = 15'b011_0000_00_0001_00;
    logic [14:0] wt     = 15'b110_0000_00_0000_00;
    logic [14:0] done   = 15'b110_0000_00_0010_01;
    logic [14:0] exp4 [8];
    logic [14:0] exp1 [8];
    exp4 = '{C_FETCH_GO, C_DECODE, ex_mdu, wt, wt, wt, done, C_FETCH_GO};
    exp1 = '{C_FETCH_GO, C_DECODE, ex_mdu, done, C_FETCH_GO, C_DECODE, ex_mdu, done};
    do_reset();
    opcode = 6'h00; funct = 6'h18;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1);
      checks++;
      if (ctl !== exp4[i]) begin errors++; $display("FAIL mult4_ctl c%0d: got %b expected %b", i + 1, ctl, exp4[i]); end
      checks++;
      if (m1_ctl !== exp1[i]) begin errors++; $display("FAIL mult1_ctl c%0d: got %b expected %b", i + 1, m1_ctl, exp1[i]); end
    end
    checks++;
    if (retired_cnt !== 32'd1) begin errors++; $display("FAIL mult4_cnt: got %0d expected 1", retired_cnt); end
    checks++;
    if (m1_retired_cnt !== 2'd1) begin errors++; $display("FAIL mult1_cnt: got %0d expected 1", m1_retired_cnt); end
  endtask

  task automatic test_trap();
    logic [14:0] trap = 15'b111_0000_00_0000_10;
    do_reset();
    opcode = 6'h3F;
    cyc(1'b1);
    cyc(1'b1);
    checks++;
    if (ctl !== C_DECODE) begin errors++; $display("FAIL trap_decode: got %b expected %b", ctl, C_DECODE); end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1);
      checks++;
      if (ctl !== trap) begin errors++; $display("FAIL trap_hold c%0d: got %b expected %b", i, ctl, trap); end
    end
    checks++;
    if (retired_cnt !== 32'd0) begin errors++; $display("FAIL trap_cnt: got %0d expected 0", retired_cnt); end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    do_reset();
    opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 21; i++) begin
      cyc(1'b1);
      if (retire) pulses++;
    end
    checks++;
    if (pulses !== 5) begin errors++; $display("FAIL wrap_pulses: got %0d expected 5", pulses); end
    checks++;
    if (retired_cnt !== 32'd5) begin errors++; $display("FAIL wrap_cnt32: got %0d expected 5", retired_cnt); end
    checks++;
    if (m1_retired_cnt !== 2'd1) begin errors++; $display("FAIL wrap_cnt2: got %0d expected 1", m1_retired_cnt); end
  endtask

  task automatic test_reset_mid_mem();
    logic [14:0] mem_wait = 15'b100_1000_00_0000_00;
    do_reset();
    opcode = 6'h23;
    cyc(1'b1);
    checks++;
    if (ctl !== C_FETCH_GO) begin errors++; $display("FAIL mid_first_fetch: got %b expected %b", ctl, C_FETCH_GO); end
    repeat (7) cyc(1'b1);
    cyc(1'b0);
    checks++;
    if (ctl !== mem_wait) begin errors++; $display("FAIL mid_mem_wait: got %b expected %b", ctl, mem_wait); end
    checks++;
    if (retired_cnt !== 32'd1) begin errors++; $display("FAIL mid_cnt_before: got %0d expected 1", retired_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== 15'd0) begin errors++; $display("FAIL mid_async_ctl: got %b expected %b", ctl, 15'd0); end
    checks++;
    if (retired_cnt !== 32'd0) begin errors++; $display("FAIL mid_async_cnt: got %0d expected 0", retired_cnt); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_sw();
    test_branch_jump();
    test_mdu();
    test_trap();
    test_wrap();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
